// File: rtl/regfile_seq_pkg.sv
// Shared types for the register-file sequencer: opcode and FSM state encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_seq_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_MOVE = 2'b01,
        OP_ADD  = 2'b10,
        OP_READ = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_B  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_sequencer.sv
// Command-driven master for a small register file: LOAD/MOVE/ADD/READ, one response per command.
// Latency accept->res_valid: LOAD 2, READ 2, MOVE 3, ADD 4 cycles.
// Backpressure: cmd_ready only in IDLE; res_ready low parks the FSM in RESP with outputs held.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] rf_r_address,
    input  logic [DATA_W-1:0] rf_q,
    output logic [ADDR_W-1:0] rf_w_address,
    output logic [DATA_W-1:0] rf_data,
    output logic              rf_we,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_carry
);

    state_e            state;
    state_e            state_nxt;

    // Latched command fields, valid from the accept edge until the next accept.
    op_e               op_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] src_a_q;
    logic [ADDR_W-1:0] src_b_q;
    logic [DATA_W-1:0] imm_q;

    // Operands captured from the register file during RD_A / RD_B.
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;

    // Response payload, registered so it stays stable while RESP is stalled.
    logic [DATA_W-1:0] res_data_q;
    logic              res_carry_q;

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] wr_data;
    logic              accept;

    assign accept = (state == S_IDLE) && cmd_valid;
    assign sum    = {1'b0, a_reg} + {1'b0, b_reg};

    // Select the value to be written for the latched opcode.
    always_comb begin
        wr_data = a_reg;
        case (op_q)
            OP_LOAD: wr_data = imm_q;
            OP_MOVE: wr_data = a_reg;
            OP_ADD:  wr_data = sum[DATA_W-1:0];
            default: wr_data = a_reg;
        endcase
    end

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = (op_e'(cmd_op) == OP_LOAD) ? S_WRITE : S_RD_A;
                end
            end
            S_RD_A: begin
                case (op_q)
                    OP_ADD:  state_nxt = S_RD_B;
                    OP_READ: state_nxt = S_RESP;
                    default: state_nxt = S_WRITE;
                endcase
            end
            S_RD_B:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_RESP;
            S_RESP: begin
                if (res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; unused addresses and write data are parked at zero.
    always_comb begin
        cmd_ready    = 1'b0;
        rf_r_address = '0;
        rf_w_address = '0;
        rf_data      = '0;
        rf_we        = 1'b0;
        res_valid    = 1'b0;
        case (state)
            S_IDLE: cmd_ready = 1'b1;
            S_RD_A: rf_r_address = src_a_q;
            S_RD_B: rf_r_address = src_b_q;
            S_WRITE: begin
                rf_we        = 1'b1;
                rf_w_address = dst_q;
                rf_data      = wr_data;
            end
            S_RESP: res_valid = 1'b1;
            default: cmd_ready = 1'b0;
        endcase
    end

    assign res_data  = res_data_q;
    assign res_carry = res_carry_q;

    // Command latch, operand capture and response payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= OP_LOAD;
            dst_q       <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            imm_q       <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            res_data_q  <= '0;
            res_carry_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= op_e'(cmd_op);
                dst_q   <= cmd_dst;
                src_a_q <= cmd_src_a;
                src_b_q <= cmd_src_b;
                imm_q   <= cmd_imm;
            end
            if (state == S_RD_A) begin
                a_reg <= rf_q;
                // READ skips WRITE, so its response is the value seen here.
                if (op_q == OP_READ) begin
                    res_data_q  <= rf_q;
                    res_carry_q <= 1'b0;
                end
            end
            if (state == S_RD_B) begin
                b_reg <= rf_q;
            end
            if (state == S_WRITE) begin
                res_data_q  <= wr_data;
                res_carry_q <= (op_q == OP_ADD) ? sum[DATA_W] : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed and random-stream bench for regfile_sequencer against a 4x4 register file.
// Latency: checks accept->res_valid cycle counts per opcode.
// Backpressure: exercises res_ready stall and mid-command reset.
module tb_regfile_sequencer;
    import regfile_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_src_a;
    logic [1:0] cmd_src_b;
    logic [3:0] cmd_imm;
    logic [1:0] rf_r_address;
    logic [3:0] rf_q;
    logic [1:0] rf_w_address;
    logic [3:0] rf_data;
    logic       rf_we;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_data;
    logic       res_carry;

    int vectors     = 0;
    int miscompares = 0;

    // Register file target: writes only when rf_we is high, combinational read.
    logic [3:0] rf_mem [4];
    int         we_count = 0;
    logic [1:0] last_waddr;
    logic [3:0] last_wdata;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_we) begin
            rf_mem[rf_w_address] <= rf_data;
            we_count             <= we_count + 1;
            last_waddr           <= rf_w_address;
            last_wdata           <= rf_data;
        end
    end

    assign rf_q = rf_mem[rf_r_address];

    regfile_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_dst      (cmd_dst),
        .cmd_src_a    (cmd_src_a),
        .cmd_src_b    (cmd_src_b),
        .cmd_imm      (cmd_imm),
        .rf_r_address (rf_r_address),
        .rf_q         (rf_q),
        .rf_w_address (rf_w_address),
        .rf_data      (rf_data),
        .rf_we        (rf_we),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_carry    (res_carry)
    );

    // Issue one command from IDLE and wait (bounded) for res_valid; returns observations.
    task automatic do_cmd(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] sa,
                          input logic [1:0] sb, input logic [3:0] imm,
                          output logic [3:0] data, output logic carry,
                          output int lat, output int wes);
        int w0;
        w0        = we_count;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src_a = sa;
        cmd_src_b = sb;
        cmd_imm   = imm;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!res_valid) lat = -1;
        data  = res_data;
        carry = res_carry;
        wes   = we_count - w0;
    endtask

    // Complete the response handshake (res_ready must be high).
    task automatic ack();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (cmd_ready !== 1'b1 || rf_we !== 1'b0 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rdy=%b we=%b vld=%b expected 1 0 0", cmd_ready, rf_we, res_valid);
        end
        vectors++;
        if (res_data !== 4'h0 || res_carry !== 1'b0 || rf_data !== 4'h0 ||
            rf_r_address !== 2'd0 || rf_w_address !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_data: got d=%h c=%b wd=%h ra=%0d wa=%0d expected all 0",
                     res_data, res_carry, rf_data, rf_r_address, rf_w_address);
        end
    endtask

    task automatic test_load();
        logic [3:0] d; logic c; int lat, wes;
        do_cmd(OP_LOAD, 2'd2, 2'd0, 2'd0, 4'hA, d, c, lat, wes);
        ack();
        vectors++;
        if (d !== 4'hA || c !== 1'b0) begin
            miscompares++;
            $display("FAIL load_res: got %h/%b expected a/0", d, c);
        end
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL load_latency: got %0d expected 2", lat);
        end
        vectors++;
        if (wes !== 1 || last_waddr !== 2'd2 || last_wdata !== 4'hA || rf_mem[2] !== 4'hA) begin
            miscompares++;
            $display("FAIL load_write: got pulses=%0d addr=%0d data=%h expected 1 2 a", wes, last_waddr, last_wdata);
        end
        vectors++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL load_return_idle: got rdy=%b vld=%b expected 1 0", cmd_ready, res_valid);
        end
        // r0 gets a known value for later reads.
        do_cmd(OP_LOAD, 2'd0, 2'd0, 2'd0, 4'h5, d, c, lat, wes);
        ack();
    endtask

    task automatic test_add();
        logic [3:0] d; logic c; int lat, wes;
        do_cmd(OP_LOAD, 2'd1, 2'd0, 2'd0, 4'h9, d, c, lat, wes);
        ack();
        do_cmd(OP_LOAD, 2'd3, 2'd0, 2'd0, 4'h8, d, c, lat, wes);
        ack();
        do_cmd(OP_ADD, 2'd0, 2'd1, 2'd3, 4'hF, d, c, lat, wes);
        ack();
        vectors++;
        if (d !== 4'h1 || c !== 1'b1) begin
            miscompares++;
            $display("FAIL add_res: got %h/%b expected 1/1", d, c);
        end
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL add_latency: got %0d expected 4", lat);
        end
        vectors++;
        if (wes !== 1 || last_waddr !== 2'd0 || last_wdata !== 4'h1) begin
            miscompares++;
            $display("FAIL add_write: got pulses=%0d addr=%0d data=%h expected 1 0 1", wes, last_waddr, last_wdata);
        end
        do_cmd(OP_READ, 2'd0, 2'd0, 2'd0, 4'h0, d, c, lat, wes);
        ack();
        vectors++;
        if (d !== 4'h1 || c !== 1'b0 || lat !== 2 || wes !== 0) begin
            miscompares++;
            $display("FAIL read_r0: got d=%h c=%b lat=%0d we=%0d expected 1 0 2 0", d, c, lat, wes);
        end
    endtask

    task automatic test_move();
        logic [3:0] d; logic c; int lat, wes;
        do_cmd(OP_MOVE, 2'd1, 2'd1, 2'd0, 4'h0, d, c, lat, wes);
        ack();
        vectors++;
        if (d !== 4'h9 || c !== 1'b0 || lat !== 3 || wes !== 1) begin
            miscompares++;
            $display("FAIL self_move: got d=%h c=%b lat=%0d we=%0d expected 9 0 3 1", d, c, lat, wes);
        end
        do_cmd(OP_READ, 2'd0, 2'd1, 2'd0, 4'h0, d, c, lat, wes);
        ack();
        vectors++;
        if (d !== 4'h9) begin
            miscompares++;
            $display("FAIL read_after_move: got %h expected 9", d);
        end
    endtask

    task automatic test_stall();
        logic [3:0] d; logic c; int lat, wes, w0;
        res_ready = 1'b0;
        w0 = we_count;
        do_cmd(OP_READ, 2'd0, 2'd3, 2'd0, 4'h0, d, c, lat, wes);
        vectors++;
        if (d !== 4'h8 || lat !== 2) begin
            miscompares++;
            $display("FAIL stall_first: got d=%h lat=%0d expected 8 2", d, lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (res_valid !== 1'b1 || res_data !== 4'h8 || cmd_ready !== 1'b0 || rf_we !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold: cycle %0d got vld=%b d=%h rdy=%b we=%b expected 1 8 0 0",
                         i, res_valid, res_data, cmd_ready, rf_we);
            end
        end
        res_ready = 1'b1;
        ack();
        vectors++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || we_count !== w0) begin
            miscompares++;
            $display("FAIL stall_release: got vld=%b rdy=%b writes=%0d expected 0 1 0",
                     res_valid, cmd_ready, we_count - w0);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] d; logic c; int lat, wes, w0;
        bit bad;
        w0        = we_count;
        cmd_op    = OP_ADD;
        cmd_dst   = 2'd2;
        cmd_src_a = 2'd1;
        cmd_src_b = 2'd3;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        // Now in RD_B.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (cmd_ready !== 1'b1 || res_valid !== 1'b0 || rf_we !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_idle: got rdy=%b vld=%b we=%b expected 1 0 0", cmd_ready, res_valid, rf_we);
        end
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (res_valid !== 1'b0 || rf_we !== 1'b0) bad = 1'b1;
        end
        vectors++;
        if (bad || we_count !== w0) begin
            miscompares++;
            $display("FAIL midreset_quiet: got stray=%b writes=%0d expected 0 0", bad, we_count - w0);
        end
        do_cmd(OP_READ, 2'd0, 2'd2, 2'd0, 4'h0, d, c, lat, wes);
        ack();
        vectors++;
        if (d !== 4'hA) begin
            miscompares++;
            $display("FAIL midreset_preserve: got %h expected a", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] model [4];
        logic [3:0] d; logic c; int lat, wes;
        logic [1:0] op, dst, sa, sb;
        logic [3:0] imm, exp_d;
        logic [4:0] s;
        logic exp_c;
        int exp_lat, exp_w;
        bit bad;
        for (int r = 0; r < 4; r++) begin
            imm = 4'($urandom_range(0, 15));
            do_cmd(OP_LOAD, 2'(r), 2'd0, 2'd0, imm, d, c, lat, wes);
            ack();
            model[r] = imm;
        end
        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            dst = 2'($urandom_range(0, 3));
            sa  = 2'($urandom_range(0, 3));
            sb  = 2'($urandom_range(0, 3));
            imm = 4'($urandom_range(0, 15));
            exp_c = 1'b0;
            exp_w = 1;
            case (op)
                2'b00: begin exp_d = imm;        exp_lat = 2; end
                2'b01: begin exp_d = model[sa];  exp_lat = 3; end
                2'b10: begin
                    s       = {1'b0, model[sa]} + {1'b0, model[sb]};
                    exp_d   = s[3:0];
                    exp_c   = s[4];
                    exp_lat = 4;
                end
                default: begin exp_d = model[sa]; exp_lat = 2; exp_w = 0; end
            endcase
            if (op != 2'b11) model[dst] = exp_d;
            do_cmd(op, dst, sa, sb, imm, d, c, lat, wes);
            ack();
            bad = (d !== exp_d) || (c !== exp_c) || (lat !== exp_lat) || (wes !== exp_w);
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL stream[%0d] op=%0d dst=%0d a=%0d b=%0d: got d=%h c=%b lat=%0d we=%0d expected %h %b %0d %0d",
                         i, op, dst, sa, sb, d, c, lat, wes, exp_d, exp_c, exp_lat, exp_w);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_dst   = 2'd0;
        cmd_src_a = 2'd0;
        cmd_src_b = 2'd0;
        cmd_imm   = 4'h0;
        res_ready = 1'b1;
        test_reset();
        test_load();
        test_add();
        test_move();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
